pc_address_path: RTL and testbench
==================================

// Module: pc_address_path
// PURPOSE
//  Fetch-side address datapath of the A09 core: 8-way PC-source mux -> program counter -> 4-way address-source mux.
//  Selects the next PC value, holds and increments the PC, and presents the selected address to the MAR input.
//  Purely datapath: the control unit drives all selects and enables; the MAR register is external.
// PARAMETERS
//  DATA_WIDTH    8      width of PC, mux inputs and outputs
//  RESET_VECTOR  8'hFF  constant on PC-mux input 2 (DATA_WIDTH bits)
// PORTS
//  clk_i       in   1    single clock; PC updates on the FALLING edge
//  reset_i     in   1    asynchronous, active-high reset of the PC
//  pc_src_i    in   3    PC-mux select
//  pc_d0_i     in   W    PC-mux input 0
//  pc_d1_i     in   W    PC-mux input 1
//  pc_d3_i     in   W    PC-mux input 3
//  ld_ni       in   1    active-low PC load enable
//  inc_ni      in   1    active-low PC increment enable
//  addr_src_i  in   2    address-mux select
//  addr_d1_i   in   W    address-mux input 1
//  addr_d2_i   in   W    address-mux input 2
//  addr_d3_i   in   W    address-mux input 3
//  pc_next_o   out  W    PC-mux output (combinational)
//  pc_o        out  W    program counter value
//  addr_o      out  W    address-mux output to MAR (combinational)
// BEHAVIOUR
//  - Reset is one clock, asynchronous and active-high.
//    reset_i=1 clears pc_o to 0 immediately, independent of the clock.
//    Reset overrides ld_ni and inc_ni, and holds the PC at 0 while asserted.
//  - PC-mux (combinational, 0 latency), selected by pc_src_i:
//    0=pc_d0_i, 1=pc_d1_i, 2=RESET_VECTOR, 3=pc_d3_i, 4..7=all zeros.
//    pc_next_o shows the selected value. No X/Z output for any select value.
//  - PC register, updated on the falling edge of clk_i when reset_i=0, priority top-down:
//    ld_ni=0             -> pc_o <= pc_next_o
//    ld_ni=1, inc_ni=0   -> pc_o <= pc_o + 1 (mod 2^W; all-ones wraps to 0)
//    ld_ni=1, inc_ni=1   -> hold
//    ld_ni=0 and inc_ni=0 together -> load wins, no increment.
//  - Address mux (combinational, 0 latency), selected by addr_src_i:
//    0=pc_o, 1=addr_d1_i, 2=addr_d2_i, 3=addr_d3_i.
//    A PC change is visible on addr_o in the same falling-edge cycle.
//  - Control-unit timing: drives selects and enables after the rising edge; the PC acts on the following falling edge.
//  - Reset releasing near a falling edge: the PC takes no action until the first falling edge with reset_i=0.
//  - Widths: all data paths are exactly W bits. No carry or overflow output.
// TESTING
//  1. reset_i=1, addr_src=0 -> pc_o=00, addr_o=00 at once, no clock edge needed; holds through edges while asserted.
//  2. reset_i=0, pc_src=2, ld_ni=0, one falling edge -> pc_o=FF, pc_next_o=FF; addr_src=0 -> addr_o=FF.
//  3. pc_o=FF, ld_ni=1, inc_ni=0, two falling edges -> pc_o=00 then 01 (wrap).
//  4. pc_src=0, pc_d0=3C, ld_ni=0, inc_ni=0, falling edge -> pc_o=3C (load wins).
//     Then ld_ni=1, inc_ni=1 for 3 edges -> pc_o stays 3C.
//  5. addr_d1=11, addr_d2=22, addr_d3=33, step addr_src 1,2,3 -> addr_o=11,22,33 with no clock.
//     pc_src=4..7 -> pc_next_o=00.
//  6. Counting up from 10 with inc_ni=0, assert reset_i mid-cycle (between edges) -> pc_o=00 immediately.
//     Deassert reset_i -> counting resumes from 00 (01 on the next falling edge).

Source files
------------

// File: rtl/pc_address_path.sv
// Fetch-side address datapath: PC-source mux, falling-edge program counter,
// and address-source mux feeding the external MAR.
module pc_address_path #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [2:0]            pc_src_i,
    input  logic [DATA_WIDTH-1:0] pc_d0_i,
    input  logic [DATA_WIDTH-1:0] pc_d1_i,
    input  logic [DATA_WIDTH-1:0] pc_d3_i,
    input  logic                  ld_ni,
    input  logic                  inc_ni,
    input  logic [1:0]            addr_src_i,
    input  logic [DATA_WIDTH-1:0] addr_d1_i,
    input  logic [DATA_WIDTH-1:0] addr_d2_i,
    input  logic [DATA_WIDTH-1:0] addr_d3_i,
    output logic [DATA_WIDTH-1:0] pc_next_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] addr_o
);

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_W  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] pc_next_s;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] addr_s;

    // PC-source mux; unused selects drive zeros so the output is never X.
    always_comb begin
        pc_next_s = ZERO_W;
        case (pc_src_i)
            3'd0:    pc_next_s = pc_d0_i;
            3'd1:    pc_next_s = pc_d1_i;
            3'd2:    pc_next_s = RESET_VECTOR;
            3'd3:    pc_next_s = pc_d3_i;
            default: pc_next_s = ZERO_W;
        endcase
    end

    // Next PC: load has priority over increment; increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (!ld_ni) begin
            pc_d = pc_next_s;
        end else if (!inc_ni) begin
            pc_d = pc_q + ONE_W;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register: acts on the falling edge so the control unit can set up after the rising edge.
    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= ZERO_W;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Address-source mux toward the MAR.
    always_comb begin
        addr_s = pc_q;
        case (addr_src_i)
            2'd0:    addr_s = pc_q;
            2'd1:    addr_s = addr_d1_i;
            2'd2:    addr_s = addr_d2_i;
            2'd3:    addr_s = addr_d3_i;
            default: addr_s = pc_q;
        endcase
    end

    assign pc_next_o = pc_next_s;
    assign pc_o      = pc_q;
    assign addr_o    = addr_s;

endmodule

// File: tb/tb_pc_address_path.sv
// Self-checking bench for pc_address_path: vector table driven through a
// scoreboard queue, plus hand-written reset and wrap sequences.
module tb_pc_address_path;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [2:0] pc_src_i = 3'd0;
    logic [7:0] pc_d0_i = 8'h00, pc_d1_i = 8'h00, pc_d3_i = 8'h00;
    logic       ld_ni = 1'b1, inc_ni = 1'b1;
    logic [1:0] addr_src_i = 2'd0;
    logic [7:0] addr_d1_i = 8'h00, addr_d2_i = 8'h00, addr_d3_i = 8'h00;
    logic [7:0] pc_next_o, pc_o, addr_o;

    int checks = 0;
    int failures = 0;

    pc_address_path #(.DATA_WIDTH(8), .RESET_VECTOR(8'hFF)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .pc_src_i(pc_src_i),
        .pc_d0_i(pc_d0_i), .pc_d1_i(pc_d1_i), .pc_d3_i(pc_d3_i),
        .ld_ni(ld_ni), .inc_ni(inc_ni), .addr_src_i(addr_src_i),
        .addr_d1_i(addr_d1_i), .addr_d2_i(addr_d2_i), .addr_d3_i(addr_d3_i),
        .pc_next_o(pc_next_o), .pc_o(pc_o), .addr_o(addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         do_edge;
        logic [2:0] pc_src;
        logic [7:0] d0, d1, d3;
        logic       ld_n, inc_n;
        logic [1:0] addr_src;
        logic [7:0] a1, a2, a3;
        logic [7:0] exp_next, exp_pc, exp_addr;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] exp_next, exp_pc, exp_addr;
    } exp_t;

    vec_t vecs[17];
    exp_t sb_q[$];

    function automatic vec_t mk(bit e, logic [2:0] ps, logic [7:0] d0, logic [7:0] d1,
                                logic [7:0] d3, logic ld, logic inc, logic [1:0] as,
                                logic [7:0] a1, logic [7:0] a2, logic [7:0] a3,
                                logic [7:0] en, logic [7:0] ep, logic [7:0] ea);
        vec_t v;
        v.do_edge = e; v.pc_src = ps; v.d0 = d0; v.d1 = d1; v.d3 = d3;
        v.ld_n = ld; v.inc_n = inc; v.addr_src = as;
        v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.exp_next = en; v.exp_pc = ep; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: got 0 entries expected >=1");
        end else begin
            checks--;
            e = sb_q.pop_front();
            check($sformatf("vec%0d_pc_next", e.idx), pc_next_o, e.exp_next);
            check($sformatf("vec%0d_pc", e.idx), pc_o, e.exp_pc);
            check($sformatf("vec%0d_addr", e.idx), addr_o, e.exp_addr);
        end
    endtask

    initial begin
        // Starting from PC=00 after reset.
        //           edge ps    d0     d1     d3     ld    inc   as    a1     a2     a3     next   pc     addr
        vecs[0]  = mk(1, 3'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        vecs[1]  = mk(1, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
        vecs[2]  = mk(1, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h01);
        vecs[3]  = mk(1, 3'd0, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C);
        vecs[4]  = mk(1, 3'd0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C);
        vecs[5]  = mk(1, 3'd0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C);
        vecs[6]  = mk(1, 3'd0, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C);
        vecs[7]  = mk(0, 3'd0, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd1, 8'h11, 8'h22, 8'h33, 8'h3C, 8'h3C, 8'h11);
        vecs[8]  = mk(0, 3'd0, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h3C, 8'h3C, 8'h22);
        vecs[9]  = mk(0, 3'd0, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'h3C, 8'h3C, 8'h33);
        vecs[10] = mk(0, 3'd4, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h3C, 8'h33);
        vecs[11] = mk(0, 3'd5, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h3C, 8'h33);
        vecs[12] = mk(0, 3'd6, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h3C, 8'h33);
        vecs[13] = mk(0, 3'd7, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h3C, 8'h33);
        vecs[14] = mk(0, 3'd1, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd0, 8'h11, 8'h22, 8'h33, 8'h5A, 8'h3C, 8'h3C);
        vecs[15] = mk(0, 3'd3, 8'h3C, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'd0, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h3C, 8'h3C);
        vecs[16] = mk(1, 3'd1, 8'h3C, 8'h5A, 8'hA5, 1'b0, 1'b1, 2'd0, 8'h11, 8'h22, 8'h33, 8'h5A, 8'h5A, 8'h5A);

        // Asynchronous reset: visible at once, before any clock edge.
        #1 reset_i = 1'b1;
        #1;
        check("rst_immediate_pc", pc_o, 8'h00);
        check("rst_immediate_addr", addr_o, 8'h00);
        // Reset overrides a pending load across falling edges.
        pc_src_i = 3'd3; pc_d3_i = 8'hAA; ld_ni = 1'b0; inc_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_hold_pc", pc_o, 8'h00);
        check("rst_hold_next", pc_next_o, 8'hAA);
        @(posedge clk_i) #1;
        ld_ni = 1'b1; inc_ni = 1'b1; reset_i = 1'b0;

        for (int i = 0; i < 17; i++) begin
            exp_t e;
            @(posedge clk_i) #1;
            pc_src_i = vecs[i].pc_src; pc_d0_i = vecs[i].d0; pc_d1_i = vecs[i].d1;
            pc_d3_i = vecs[i].d3; ld_ni = vecs[i].ld_n; inc_ni = vecs[i].inc_n;
            addr_src_i = vecs[i].addr_src; addr_d1_i = vecs[i].a1;
            addr_d2_i = vecs[i].a2; addr_d3_i = vecs[i].a3;
            e.idx = i; e.exp_next = vecs[i].exp_next;
            e.exp_pc = vecs[i].exp_pc; e.exp_addr = vecs[i].exp_addr;
            sb_q.push_back(e);
            if (vecs[i].do_edge) begin
                @(negedge clk_i) #1;
            end else begin
                #1;
            end
            pop_compare();
        end

        // Count up from 10, then reset mid-cycle and resume from 00.
        @(posedge clk_i) #1;
        pc_src_i = 3'd0; pc_d0_i = 8'h10; ld_ni = 1'b0; inc_ni = 1'b1; addr_src_i = 2'd0;
        @(negedge clk_i) #1;
        check("cnt_load10", pc_o, 8'h10);
        @(posedge clk_i) #1;
        ld_ni = 1'b1; inc_ni = 1'b0;
        @(negedge clk_i) #1;
        check("cnt_11", pc_o, 8'h11);
        @(negedge clk_i) #1;
        check("cnt_12", pc_o, 8'h12);
        @(posedge clk_i) #1;
        reset_i = 1'b1;
        #1;
        check("midcycle_rst_pc", pc_o, 8'h00);
        check("midcycle_rst_addr", addr_o, 8'h00);
        @(negedge clk_i) #1;
        check("rst_held_cnt", pc_o, 8'h00);
        @(posedge clk_i) #1;
        reset_i = 1'b0;
        #1;
        check("rst_release_pc", pc_o, 8'h00);
        @(negedge clk_i) #1;
        check("resume_01", pc_o, 8'h01);
        @(negedge clk_i) #1;
        check("resume_02", pc_o, 8'h02);

        check("sb_empty", 8'(sb_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
